osd_cmd_arbiter: RTL and testbench



---
 rtl/osd_cmd_pkg.sv | 21 ++
 rtl/osd_rr_arb2.sv | 21 ++
 rtl/osd_cmd_arbiter.sv | 270 +++++++++++++++++++++++++++
 tb/tb_osd_cmd_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osd_cmd_pkg.sv
// Shared types and constants for the OSD command arbiter.
package osd_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        INJECT = 2'd2
    } osd_state_e;

    localparam logic [7:0] CMD_ENABLE = 8'd1;
    localparam logic [7:0] CMD_WRITE  = 8'd2;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Width of a counter that must hold values 0..n-1 (at least 1 bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/osd_rr_arb2.sv
// Two-way round-robin pick: on a tie the port not granted last wins.
module osd_rr_arb2
    import osd_cmd_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt_vld,
    output logic       gnt_idx
);

    // Pure combinational pick.
    always_comb begin
        gnt_vld = |req;
        gnt_idx = PORT_A;
        if (&req)
            gnt_idx = ~last_gnt;
        else if (req[PORT_B])
            gnt_idx = PORT_B;
    end

endmodule

// File: rtl/osd_cmd_arbiter.sv
// Arbitrates packets from two byte sources onto the OSD strobe interface.
// Packets are granted whole, round-robin, with strobe pacing and a stall
// timeout. Optional auto-hide injection is enabled by OSD_AUTOHIDE_EN.
module osd_cmd_arbiter
    import osd_cmd_pkg::*;
#(
    parameter int unsigned STROBE_GAP  = 0,
    parameter int unsigned TIMEOUT     = 4096,
    parameter int unsigned HIDE_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       a_valid,
    input  logic       a_start,
    input  logic       a_last,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic       b_start,
    input  logic       b_last,
    input  logic [7:0] b_data,
    output logic       b_ready,
    output logic       out_strobe,
    output logic       out_start,
    output logic [7:0] out_data,
    output logic       busy,
    output logic       abort
);

    localparam int unsigned GW = cnt_w(STROBE_GAP + 1);
    localparam int unsigned TW = cnt_w(TIMEOUT);
    localparam logic [GW-1:0] GAP_LD = GW'(STROBE_GAP);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);

    osd_state_e    state_q, state_d;
    logic          grant_q, grant_d;
    logic          rr_q, rr_d;
    logic          first_q, first_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] to_q, to_d;
    logic          run_q;
    logic          out_strobe_q, out_strobe_d;
    logic          out_start_q, out_start_d;
    logic [7:0]    out_data_q, out_data_d;

    logic [1:0]    req, rdy;
    logic          gnt_vld, gnt_idx;
    logic          g_valid, g_last;
    logic [7:0]    g_data;
    logic          gap_ok, xfer, emit, abort_w;
    logic          inj_emit, inj_first;
    logic [7:0]    inj_byte;

`ifdef OSD_AUTOHIDE_EN
    localparam int unsigned IW = cnt_w(HIDE_CYCLES);
    localparam logic [IW-1:0] IDLE_MAX = IW'(HIDE_CYCLES - 1);

    logic [IW-1:0] idle_q, idle_d;
    logic          inj_q, inj_d;
    logic          shadow_q, shadow_d;
    logic          second_q, second_d;
    logic [7:0]    cmd_q, cmd_d;

    assign inj_emit  = (state_q == INJECT) && gap_ok;
    assign inj_first = inj_emit && !inj_q;
    assign inj_byte  = inj_q ? 8'd0 : CMD_ENABLE;
`else
    // HIDE_CYCLES has no effect without auto-hide.
    assign inj_emit  = 1'b0 & (HIDE_CYCLES == 0);
    assign inj_first = 1'b0;
    assign inj_byte  = 8'd0;
`endif

    assign req     = {b_valid & b_start, a_valid & a_start};
    assign g_valid = grant_q ? b_valid : a_valid;
    assign g_last  = grant_q ? b_last  : a_last;
    assign g_data  = grant_q ? b_data  : a_data;
    assign gap_ok  = (gap_q == '0);
    assign xfer    = (state_q == BUSY) && g_valid && rdy[grant_q];
    assign emit    = xfer | inj_emit;

    osd_rr_arb2 u_rr (
        .req     (req),
        .last_gnt(rr_q),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // Port readies, abort pulse and busy flag from current state.
    always_comb begin
        rdy = 2'b00;
        case (state_q)
            IDLE:    rdy = {b_valid & ~b_start, a_valid & ~a_start};
            BUSY:    rdy[grant_q] = gap_ok;
            default: rdy = 2'b00;
        endcase
        // Nothing is accepted until the first clock after reset release.
        rdy     = rdy & {2{run_q}};
        abort_w = (state_q == BUSY) && !g_valid && (to_q == TO_MAX);
    end

    assign a_ready    = rdy[PORT_A];
    assign b_ready    = rdy[PORT_B];
    assign abort      = abort_w;
    assign busy       = (state_q != IDLE);
    assign out_strobe = out_strobe_q;
    assign out_start  = out_start_q;
    assign out_data   = out_data_q;

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld)
                    state_d = BUSY;
`ifdef OSD_AUTOHIDE_EN
                else if (idle_q == IDLE_MAX && shadow_q)
                    state_d = INJECT;
`endif
            end
            BUSY: begin
                if ((xfer && g_last) || abort_w)
                    state_d = IDLE;
            end
`ifdef OSD_AUTOHIDE_EN
            INJECT: begin
                if (inj_emit && inj_q)
                    state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Grant, pacing, timeout and output byte register updates.
    always_comb begin
        grant_d      = grant_q;
        rr_d         = rr_q;
        first_d      = first_q;
        to_d         = to_q;
        gap_d        = gap_ok ? '0 : gap_q - 1'b1;
        if (emit)
            gap_d = GAP_LD;
        out_strobe_d = emit;
        out_start_d  = (xfer & first_q) | inj_first;
        out_data_d   = out_data_q;
        if (xfer)
            out_data_d = g_data;
        else if (inj_emit)
            out_data_d = inj_byte;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    grant_d = gnt_idx;
                    first_d = 1'b1;
                    to_d    = '0;
                end
            end
            BUSY: begin
                if (xfer) begin
                    first_d = 1'b0;
                    to_d    = '0;
                    if (g_last)
                        rr_d = grant_q;
                end else if (!g_valid) begin
                    if (to_q == TO_MAX) begin
                        to_d = '0;
                        rr_d = grant_q;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef OSD_AUTOHIDE_EN
    // Idle timer, injection sequencing and snoop of ENABLE packets.
    always_comb begin
        idle_d   = idle_q;
        inj_d    = inj_q;
        shadow_d = shadow_q;
        second_d = second_q;
        cmd_d    = cmd_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    idle_d   = '0;
                    second_d = 1'b0;
                end else if (idle_q != IDLE_MAX) begin
                    idle_d = idle_q + 1'b1;
                end else if (shadow_q) begin
                    idle_d = '0;
                    inj_d  = 1'b0;
                end
            end
            BUSY: begin
                if (xfer) begin
                    second_d = first_q;
                    if (first_q)
                        cmd_d = g_data;
                    else if (second_q && cmd_q == CMD_ENABLE)
                        shadow_d = g_data[0];
                end
            end
            INJECT: begin
                if (inj_emit) begin
                    inj_d = 1'b1;
                    if (inj_q)
                        shadow_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Auto-hide state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_q   <= '0;
            inj_q    <= 1'b0;
            shadow_q <= 1'b0;
            second_q <= 1'b0;
            cmd_q    <= 8'd0;
        end else begin
            idle_q   <= idle_d;
            inj_q    <= inj_d;
            shadow_q <= shadow_d;
            second_q <= second_d;
            cmd_q    <= cmd_d;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Datapath registers; rr starts at B so A wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q      <= PORT_A;
            rr_q         <= PORT_B;
            first_q      <= 1'b0;
            gap_q        <= '0;
            to_q         <= '0;
            run_q        <= 1'b0;
            out_strobe_q <= 1'b0;
            out_start_q  <= 1'b0;
            out_data_q   <= 8'd0;
        end else begin
            grant_q      <= grant_d;
            rr_q         <= rr_d;
            first_q      <= first_d;
            gap_q        <= gap_d;
            to_q         <= to_d;
            run_q        <= 1'b1;
            out_strobe_q <= out_strobe_d;
            out_start_q  <= out_start_d;
            out_data_q   <= out_data_d;
        end
    end

endmodule

// File: tb/tb_osd_cmd_arbiter.sv
// Directed bench for osd_cmd_arbiter: one instance with STROBE_GAP=0 and one
// with STROBE_GAP=2. Auto-hide checks run when OSD_AUTOHIDE_EN is defined.
module tb_osd_cmd_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       a_valid, a_start, a_last, a_ready;
    logic       b_valid, b_start, b_last, b_ready;
    logic [7:0] a_data, b_data, out_data;
    logic       out_strobe, out_start, busy, abort;

    logic       g_a_valid, g_a_start, g_a_last, g_a_ready;
    logic       g_b_valid, g_b_start, g_b_last, g_b_ready;
    logic [7:0] g_a_data, g_b_data, g_out_data;
    logic       g_out_strobe, g_out_start, g_busy, g_abort;

    osd_cmd_arbiter #(.STROBE_GAP(0), .TIMEOUT(16), .HIDE_CYCLES(100)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_start(a_start), .a_last(a_last), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_start(b_start), .b_last(b_last), .b_data(b_data), .b_ready(b_ready),
        .out_strobe(out_strobe), .out_start(out_start), .out_data(out_data),
        .busy(busy), .abort(abort)
    );

    osd_cmd_arbiter #(.STROBE_GAP(2), .TIMEOUT(16), .HIDE_CYCLES(100)) u_dut_g2 (
        .clk(clk), .reset_n(reset_n),
        .a_valid(g_a_valid), .a_start(g_a_start), .a_last(g_a_last), .a_data(g_a_data), .a_ready(g_a_ready),
        .b_valid(g_b_valid), .b_start(g_b_start), .b_last(g_b_last), .b_data(g_b_data), .b_ready(g_b_ready),
        .out_strobe(g_out_strobe), .out_start(g_out_start), .out_data(g_out_data),
        .busy(g_busy), .abort(g_abort)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Cycle stamps and logs, sampled on the falling edge.
    int         cyc = 0;
    int         s_cyc[$];
    logic [8:0] s_val[$];
    int         x_cyc[$];
    int         ab_cyc[$];
    int         g_cyc[$];
    logic [8:0] g_val[$];
    int         g_stall = 0;
    int         g_ab = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_strobe) begin
            s_cyc.push_back(cyc);
            s_val.push_back({out_start, out_data});
        end
        if ((a_valid && a_ready) || (b_valid && b_ready)) x_cyc.push_back(cyc);
        if (abort) ab_cyc.push_back(cyc);
        if (g_out_strobe) begin
            g_cyc.push_back(cyc);
            g_val.push_back({g_out_start, g_out_data});
        end
        if (g_busy && g_a_valid && !g_a_ready) g_stall++;
        if (g_abort) g_ab++;
    end

    function automatic int sv(input int i);
        return (i < s_val.size()) ? int'(s_val[i]) : -1;
    endfunction
    function automatic int sc(input int i);
        return (i < s_cyc.size()) ? s_cyc[i] : -1000;
    endfunction
    function automatic int xc(input int i);
        return (i < x_cyc.size()) ? x_cyc[i] : -1000;
    endfunction
    function automatic int ac(input int i);
        return (i < ab_cyc.size()) ? ab_cyc[i] : -1000;
    endfunction
    function automatic int gc(input int i);
        return (i < g_cyc.size()) ? g_cyc[i] : -1000;
    endfunction
    function automatic int gv(input int i);
        return (i < g_val.size()) ? int'(g_val[i]) : -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // p: 0 = port A, 1 = port B, 2 = port A of the gap instance.
    task automatic set_port(input int p, input logic v, input logic s, input logic l, input logic [7:0] d);
        if (p == 0) begin
            a_valid = v; a_start = s; a_last = l; a_data = d;
        end else if (p == 1) begin
            b_valid = v; b_start = s; b_last = l; b_data = d;
        end else begin
            g_a_valid = v; g_a_start = s; g_a_last = l; g_a_data = d;
        end
    endtask

    function automatic logic port_rdy(input int p);
        return (p == 0) ? a_ready : (p == 1) ? b_ready : g_a_ready;
    endfunction

    // Sends n bytes (first byte in bits 7:0); open leaves the packet unterminated.
    // Entered and left just after a rising edge.
    task automatic drv(input int p, input logic [31:0] bytes, input int n, input bit open);
        for (int i = 0; i < n; i++) begin
            int   k;
            logic r;
            set_port(p, 1'b1, i == 0, (i == n - 1) && !open, bytes[8*i +: 8]);
            k = 0;
            @(negedge clk);
            r = port_rdy(p);
            while (!r && k < 100) begin
                @(negedge clk);
                r = port_rdy(p);
                k++;
            end
            if (!r) chk("handshake_timeout", {31'd0, r}, 32'd1);
            @(posedge clk);
            #1;
        end
        set_port(p, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_port(0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0);
        set_port(2, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        s_cyc.delete(); s_val.delete(); x_cyc.delete(); ab_cyc.delete();
        g_cyc.delete(); g_val.delete(); g_stall = 0; g_ab = 0;
        reset_n = 1'b1;
        tick(1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int snap;
        int k;
        g_b_valid = 0; g_b_start = 0; g_b_last = 0; g_b_data = 0;
        reset_n = 1'b0;
        set_port(0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0);
        set_port(2, 0, 0, 0, 0);
        tick(2);
        chk("rst_strobe", out_strobe, 0);
        chk("rst_start", out_start, 0);
        chk("rst_data", out_data, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_abort", abort, 0);

        // Single 3-byte packet, back-to-back strobes, latency 1.
        do_reset();
        drv(0, 32'h00AA0502, 3, 0);
        tick(2);
        chk("p1_count", s_val.size(), 3);
        chk("p1_b0", sv(0), 9'h102);
        chk("p1_b1", sv(1), 9'h005);
        chk("p1_b2", sv(2), 9'h0AA);
        chk("p1_spacing01", sc(1) - sc(0), 1);
        chk("p1_spacing12", sc(2) - sc(1), 1);
        chk("p1_lat0", sc(0) - xc(0), 1);
        chk("p1_lat2", sc(2) - xc(2), 1);

        // Tie from reset: A first, B right after A's last byte.
        do_reset();
        fork
            drv(0, 32'h00A2A102, 3, 0);
            drv(1, 32'h00B2B102, 3, 0);
        join
        tick(3);
        chk("tie1_a0", sv(0), 9'h102);
        chk("tie1_a2", sv(2), 9'h0A2);
        chk("tie1_b0", sv(3), 9'h102);
        chk("tie1_b1", sv(4), 9'h0B1);
        chk("tie1_b2", sv(5), 9'h0B2);
        chk("tie1_bubble", sc(3) - sc(2), 2);
        // A alone, then a tie: B must now win.
        base = s_val.size();
        drv(0, 32'h0000C102, 2, 0);
        fork
            drv(0, 32'h0000D102, 2, 0);
            drv(1, 32'h0000E102, 2, 0);
        join
        tick(3);
        chk("tie2_count", s_val.size() - base, 6);
        chk("tie2_first_b", sv(base + 3), 9'h0E1);
        chk("tie2_then_a", sv(base + 5), 9'h0D1);

        // Strobe pacing with STROBE_GAP=2.
        do_reset();
        drv(2, 32'h03020102, 4, 0);
        tick(2);
        chk("gap_count", g_val.size(), 4);
        chk("gap_b0", gv(0), 9'h102);
        chk("gap_b3", gv(3), 9'h003);
        chk("gap_sp01", gc(1) - gc(0), 3);
        chk("gap_sp12", gc(2) - gc(1), 3);
        chk("gap_sp23", gc(3) - gc(2), 3);
        chk("gap_ready_low", g_stall, 6);
        chk("gap_no_abort", g_ab, 0);
        chk("gap_b_ready", g_b_ready, 0);

        // B stalls mid-packet; A waits and is granted after the abort.
        do_reset();
        fork
            drv(1, 32'h00001102, 2, 1);
            begin
                tick(3);
                drv(0, 32'h00000007, 1, 0);
            end
        join
        tick(3);
        chk("to_abort_once", ab_cyc.size(), 1);
        chk("to_abort_cycle", ac(0) - xc(1), 16);
        chk("to_a_after", xc(2) - ac(0), 2);
        chk("to_a_byte", sv(2), 9'h107);
        chk("to_count", s_val.size(), 3);

        // Resync: non-start byte in IDLE is swallowed.
        do_reset();
        set_port(1, 1, 0, 0, 8'h77);
        @(negedge clk);
        chk("resync_ready", b_ready, 1);
        @(posedge clk);
        #1;
        set_port(1, 0, 0, 0, 0);
        tick(3);
        chk("resync_no_strobe", s_val.size(), 0);
        drv(1, 32'h00005502, 2, 0);
        tick(2);
        chk("resync_pkt_b0", sv(0), 9'h102);
        chk("resync_pkt_b1", sv(1), 9'h055);

        // Asynchronous reset in the middle of a packet.
        do_reset();
        drv(0, 32'h00003302, 2, 1);
        set_port(0, 1, 0, 0, 8'h44);
        k = 0;
        @(negedge clk);
        while (!out_strobe && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("mid_strobe_seen", out_strobe, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_strobe", out_strobe, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_a_ready", a_ready, 0);
        chk("mid_rst_busy", busy, 0);
        snap = s_val.size();
        tick(2);
        reset_n = 1'b1;
        tick(6);
        chk("mid_no_partial", s_val.size(), snap);
        set_port(0, 0, 0, 0, 0);

`ifdef OSD_AUTOHIDE_EN
        // ENABLE packet arms auto-hide; one injection after 100 idle cycles.
        do_reset();
        drv(0, 32'h00000101, 2, 0);
        tick(150);
        chk("hide_count", s_val.size(), 4);
        chk("hide_b0", sv(2), 9'h101);
        chk("hide_b1", sv(3), 9'h000);
        chk("hide_delay", sc(2) - sc(1), 101);
        chk("hide_spacing", sc(3) - sc(2), 1);
        tick(300);
        chk("hide_once", s_val.size(), 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
